// File: rtl/tree_serializer_par.sv
// N-to-1 serializer with valid/ready load, one-word holding buffer for gapless
// back-to-back frames, and selectable bit order.
module tree_serializer_par #(
   parameter int unsigned N_LANES   = 8,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_LANES-1:0] par_in,
   input  logic               par_valid,
   output logic               par_ready,
   output logic               serial_out,
   output logic               serial_valid,
   output logic               frame_start
);

   localparam int unsigned     CNT_W    = $clog2(N_LANES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_LANES - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state, state_d;
   logic [N_LANES-1:0] hold, hold_d;
   logic [N_LANES-1:0] shreg, shreg_d;
   logic               hold_full, hold_full_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic               serial_out_d, serial_valid_d, frame_start_d;
   logic               load;

   function automatic logic first_bit(input logic [N_LANES-1:0] w);
      return MSB_FIRST ? w[N_LANES-1] : w[0];
   endfunction

   assign par_ready = !hold_full;
   assign load      = hold_full && ((state == IDLE) || (cnt == LAST_CNT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         hold         <= '0;
         hold_full    <= 1'b0;
         shreg        <= '0;
         cnt          <= '0;
         serial_out   <= 1'b0;
         serial_valid <= 1'b0;
         frame_start  <= 1'b0;
      end else begin
         state        <= state_d;
         hold         <= hold_d;
         hold_full    <= hold_full_d;
         shreg        <= shreg_d;
         cnt          <= cnt_d;
         serial_out   <= serial_out_d;
         serial_valid <= serial_valid_d;
         frame_start  <= frame_start_d;
      end
   end

   // Shifting the register toward the output end keeps the next bit at a fixed position.
   always_comb begin
      state_d        = state;
      hold_d         = hold;
      hold_full_d    = hold_full;
      shreg_d        = shreg;
      cnt_d          = cnt;
      serial_out_d   = 1'b0;
      serial_valid_d = 1'b0;
      frame_start_d  = 1'b0;

      if (par_valid && !hold_full) begin
         hold_d      = par_in;
         hold_full_d = 1'b1;
      end

      if (load) begin
         shreg_d        = hold;
         hold_full_d    = 1'b0;
         cnt_d          = '0;
         state_d        = SHIFT;
         serial_out_d   = first_bit(hold);
         serial_valid_d = 1'b1;
         frame_start_d  = 1'b1;
      end else if (state == SHIFT) begin
         if (cnt != LAST_CNT) begin
            cnt_d          = cnt + CNT_W'(1);
            shreg_d        = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            serial_out_d   = first_bit(shreg_d);
            serial_valid_d = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end
   end

endmodule
